// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready slice that registers the backward (ready) path of a stream.
// Output register plus one skid register; in_ready comes straight from a flop.
module stream_skid_buffer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [1:0]             occupancy,
  input  logic                   stat_clear,
  output logic [COUNT_WIDTH-1:0] xfer_count,
  output logic [COUNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0]  skid_q, skid_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic [COUNT_WIDTH-1:0] xfer_q, xfer_d;
  logic [COUNT_WIDTH-1:0] stall_q, stall_d;
  logic                   in_fire;
  logic                   out_fire;
  logic                   out_stall;

  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid_q && out_ready;
  assign out_stall = out_valid_q && !out_ready;

  // Next-state, datapath loads and registered handshake outputs
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    skid_d     = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          out_data_d = in_data;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          out_data_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          out_data_d = skid_q;
          state_d    = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  // Saturating link statistics; clear beats any increment
  always_comb begin
    xfer_d  = xfer_q;
    stall_d = stall_q;
    if (stat_clear) begin
      xfer_d  = '0;
      stall_d = '0;
    end else begin
      if (out_fire && (xfer_q != CNT_MAX)) begin
        xfer_d = xfer_q + COUNT_WIDTH'(1);
      end
      if (out_stall && (stall_q != CNT_MAX)) begin
        stall_d = stall_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      xfer_q      <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      xfer_q      <= xfer_d;
      stall_q     <= stall_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign occupancy   = state_q;
  assign xfer_count  = xfer_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_stream_skid_buffer.sv
// Directed and random self-checking bench for stream_skid_buffer.
// A second instance with 4-bit counters covers saturation.
module tb_stream_skid_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, stat_clear;
  logic [31:0] in_data, out_data;
  logic [1:0]  occupancy;
  logic [15:0] xfer_count, stall_count;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_stat_clear;
  logic [7:0]  s_in_data, s_out_data;
  logic [1:0]  s_occ;
  logic [3:0]  s_xfer, s_stall;

  int n_cmp = 0;
  int n_err = 0;

  stream_skid_buffer #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stat_clear(stat_clear),
    .xfer_count(xfer_count), .stall_count(stall_count)
  );

  stream_skid_buffer #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occ), .stat_clear(s_stat_clear),
    .xfer_count(s_xfer), .stall_count(s_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Protocol monitor: downstream hold stability and upstream driver discipline
  logic        dn_hold_q, up_pend_q;
  logic [31:0] dn_data_q, up_data_q;
  always @(posedge clk) begin
    if (!rst_n) begin
      dn_hold_q <= 1'b0;
      up_pend_q <= 1'b0;
    end else begin
      if (dn_hold_q) begin
        chk("dn_valid_stable", 64'(out_valid), 64'(1));
        chk("dn_data_stable", 64'(out_data), 64'(dn_data_q));
      end
      if (up_pend_q) begin
        chk("up_valid_stable", 64'(in_valid), 64'(1));
        chk("up_data_stable", 64'(in_data), 64'(up_data_q));
      end
      dn_hold_q <= out_valid && !out_ready;
      dn_data_q <= out_data;
      up_pend_q <= in_valid && !in_ready;
      up_data_q <= in_data;
    end
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] dropped;
    bit          inf, outf, held;
    int          exp_x;

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stat_clear = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0; s_stat_clear = 1'b0;
    repeat (3) tick();

    // Reset then idle
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    chk("idle_out_valid", 64'(out_valid), 64'(0));
    chk("idle_occ", 64'(occupancy), 64'(0));
    chk("idle_xfer", 64'(xfer_count), 64'(0));
    chk("idle_stall", 64'(stall_count), 64'(0));
    chk("idle_data", 64'(out_data), 64'(0));

    // Full-rate stream 0x01..0x10
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      tick();
      chk("stream_valid", 64'(out_valid), 64'(1));
      chk("stream_data", 64'(out_data), 64'(i));
      chk("stream_in_ready", 64'(in_ready), 64'(1));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 64'(out_valid), 64'(0));
    chk("stream_xfer", 64'(xfer_count), 64'(16));
    chk("stream_stall", 64'(stall_count), 64'(0));

    // Backpressure: A0, A1 accepted, A2 held upstream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA0;
    tick();
    chk("bp1_occ", 64'(occupancy), 64'(1));
    chk("bp1_in_ready", 64'(in_ready), 64'(1));
    chk("bp1_data", 64'(out_data), 64'hA0);
    in_data = 32'hA1;
    tick();
    chk("bp2_occ", 64'(occupancy), 64'(2));
    chk("bp2_in_ready", 64'(in_ready), 64'(0));
    chk("bp2_stall", 64'(stall_count), 64'(1));
    in_data = 32'hA2;
    tick();
    chk("bp3_in_ready", 64'(in_ready), 64'(0));
    chk("bp3_stall", 64'(stall_count), 64'(2));
    tick();
    chk("bp4_stall", 64'(stall_count), 64'(3));
    chk("bp4_data", 64'(out_data), 64'hA0);
    chk("bp4_occ", 64'(occupancy), 64'(2));
    out_ready = 1'b1;
    tick();
    chk("bp5_data", 64'(out_data), 64'hA1);
    chk("bp5_in_ready", 64'(in_ready), 64'(1));
    chk("bp5_occ", 64'(occupancy), 64'(1));
    tick();
    chk("bp6_data", 64'(out_data), 64'hA2);
    chk("bp6_valid", 64'(out_valid), 64'(1));
    in_valid = 1'b0;
    tick();
    chk("bp7_valid", 64'(out_valid), 64'(0));
    chk("bp7_xfer", 64'(xfer_count), 64'(19));
    chk("bp7_stall", 64'(stall_count), 64'(3));

    // Clear counters before random traffic
    out_ready  = 1'b0;
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    chk("clr_xfer", 64'(xfer_count), 64'(0));
    chk("clr_stall", 64'(stall_count), 64'(0));

    // Random traffic against a queue model
    exp_x = 0;
    held  = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!held) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      out_ready = 1'($urandom_range(0, 1));
      inf  = in_valid && (q.size() < 2);
      outf = (q.size() > 0) && out_ready;
      tick();
      if (outf) begin
        dropped = q.pop_front();
        exp_x++;
      end
      if (inf) q.push_back(in_data);
      held = in_valid && !inf;
      chk("rnd_in_ready", 64'(in_ready), 64'(q.size() != 2));
      chk("rnd_out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("rnd_occ", 64'(occupancy), 64'(q.size()));
      if (q.size() != 0) chk("rnd_data", 64'(out_data), 64'(q[0]));
      chk("rnd_xfer", 64'(xfer_count), 64'(exp_x));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (!held) in_valid = 1'b0;
      inf  = in_valid && (q.size() < 2);
      outf = (q.size() > 0);
      tick();
      if (outf) begin
        dropped = q.pop_front();
        exp_x++;
      end
      if (inf) q.push_back(in_data);
      held = in_valid && !inf;
    end
    chk("drain_model_empty", 64'(q.size()), 64'(0));
    chk("drain_out_valid", 64'(out_valid), 64'(0));
    chk("drain_xfer", 64'(xfer_count), 64'(exp_x));

    // Saturation on the 4-bit counter instance
    s_in_valid = 1'b1;
    s_in_data  = 8'h77;
    tick();
    s_in_valid = 1'b0;
    chk("sat_valid", 64'(s_out_valid), 64'(1));
    chk("sat_in_ready", 64'(s_in_ready), 64'(1));
    chk("sat_stall0", 64'(s_stall), 64'(0));
    repeat (14) tick();
    chk("sat_stall14", 64'(s_stall), 64'(14));
    repeat (6) tick();
    chk("sat_stall_max", 64'(s_stall), 64'(15));
    chk("sat_occ", 64'(s_occ), 64'(1));
    s_stat_clear = 1'b1;
    tick();
    s_stat_clear = 1'b0;
    chk("sat_clear", 64'(s_stall), 64'(0));
    tick();
    chk("sat_after_clear", 64'(s_stall), 64'(1));
    chk("sat_data_held", 64'(s_out_data), 64'h77);
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_in_data = 8'(i);
      tick();
      if (i == 9) chk("sat_xfer10", 64'(s_xfer), 64'(10));
    end
    s_in_valid = 1'b0;
    tick();
    chk("sat_xfer_max", 64'(s_xfer), 64'(15));
    chk("sat_stall_kept", 64'(s_stall), 64'(1));
    chk("sat_drained", 64'(s_out_valid), 64'(0));

    // Asynchronous reset with two beats held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    in_valid = 1'b0;
    chk("prerst_occ", 64'(occupancy), 64'(2));
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    chk("arst_occ", 64'(occupancy), 64'(0));
    chk("arst_data", 64'(out_data), 64'(0));
    chk("arst_xfer", 64'(xfer_count), 64'(0));
    repeat (2) tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 32'h55;
    tick();
    in_valid = 1'b0;
    chk("fresh_valid", 64'(out_valid), 64'(1));
    chk("fresh_data", 64'(out_data), 64'h55);
    tick();
    chk("fresh_alone", 64'(out_valid), 64'(0));
    tick();
    chk("no_stale_beat", 64'(out_valid), 64'(0));
    chk("post_rst_xfer", 64'(xfer_count), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_skid_buffer.md
# stream_skid_buffer

Two-entry valid/ready register slice that registers the backward (ready) path of a stream. It complements the existing forward pipeline register, which registers valid/data. `in_ready` is driven straight from a flop, so no combinational path runs from `out_ready` to `in_ready`. The slice is placed on long or congested stream links, usually back-to-back with the forward register to form a full register slice, and carries saturating transfer and backpressure counters for link debug.

## Interface
- `DATA_WIDTH`, default 32: payload width in bits.
- `COUNT_WIDTH`, default 16: width of each statistics counter.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: upstream may transfer. Driven directly from a flop.
- `in_data` in `DATA_WIDTH`: upstream payload.
- `out_valid` out 1: downstream beat valid. Driven from a flop.
- `out_ready` in 1: downstream accepts.
- `out_data` out `DATA_WIDTH`: downstream payload. Driven from a flop.
- `occupancy` out 2: number of held beats, 0 to 2.
- `stat_clear` in 1: synchronous clear of both counters.
- `xfer_count` out `COUNT_WIDTH`: count of output transfers (`out_valid && out_ready`), saturating.
- `stall_count` out `COUNT_WIDTH`: count of cycles with `out_valid && !out_ready`, saturating.

## Operation
- Storage is an output register (`out_data`) plus one skid register.
- Input fire: `in_valid && in_ready`. Output fire: `out_valid && out_ready`.
- State machine, encoded by `occupancy`:
  - EMPTY (0): `in_ready`=1, `out_valid`=0. On input fire, load the output register and go to BUSY.
  - BUSY (1): `in_ready`=1, `out_valid`=1.
    - Input and output fire together: reload the output register from `in_data` and stay in BUSY.
    - Input fire only: write `in_data` into the skid register and go to FULL.
    - Output fire only: go to EMPTY.
    - Neither: hold.
  - FULL (2): `in_ready`=0, `out_valid`=1.
    - Output fire: output register takes the skid register, go to BUSY.
    - Otherwise hold. `in_valid` is ignored.
- Beats leave in arrival order. There is no loss and no duplication.
- `out_data` changes only on a load. When `out_valid`=0 it holds its last value.
- `in_ready` is the registered value of next-state != FULL. It never depends combinationally on `out_ready` or `in_valid`.
- Counters:
  - `xfer_count` increments on output fire.
  - `stall_count` increments when `out_valid && !out_ready`.
  - Both saturate at all-ones and never wrap.
- `stat_clear` zeroes both counters on the next edge and wins over any increment in the same cycle. It does not affect the datapath.
- Reset is asserted asynchronously, at any time including mid-burst. It forces the values below immediately. Held beats are discarded.
  - `occupancy`=0, `out_valid`=0, `in_ready`=1.
  - `out_data`=0, skid register=0.
  - `xfer_count`=0, `stall_count`=0.

## Timing
- Latency is 1 cycle from input fire to `out_valid` when empty, or to a new `out_data` when BUSY with a simultaneous output fire.
- Throughput is 1 beat/cycle sustained while `out_ready`=1.
- After `out_ready` drops with a beat held (BUSY), the block accepts exactly one more beat (the skid beat) and then deasserts `in_ready` on the following cycle.
- After `out_ready` rises in FULL, `in_ready` returns to 1 one cycle after the output fire.
- Counter outputs reflect events up to the previous edge, with 1-cycle latency.
- Upstream protocol rule: `in_data` must be stable while `in_valid && !in_ready`. `in_valid` must not drop before the beat is accepted. The bench asserts this.
- Downstream guarantee: `out_valid` and `out_data` stay stable while `out_valid && !out_ready`. The bench asserts this.

## Test plan
- Reset then idle. Expect `in_ready`=1, `out_valid`=0, `occupancy`=0, both counters 0, `out_data`=0.
- Stream 0x01..0x10 with `out_ready`=1 held. Expect output in order at 1 beat/cycle, first beat 1 cycle after its input fire, `xfer_count`=16, `stall_count`=0.
- Send 0xA0, 0xA1, 0xA2 back-to-back with `out_ready`=0.
  - Expect 0xA0 and 0xA1 accepted and `in_ready`=0 from the third cycle.
  - 0xA2 stays held upstream.
  - `occupancy`=2, `stall_count` rises by 1/cycle while `out_ready` is low.
  - After raising `out_ready`: output 0xA0, 0xA1, 0xA2 in order.
- Random `in_valid`/`out_ready` with 50% density for 10k cycles. Scoreboard shows exact in-order match. Check `in_ready` against a one-cycle-delayed model, and `xfer_count` equal to the scoreboard count.
- Saturation with `COUNT_WIDTH`=4.
  - Hold `out_valid` with `out_ready`=0 for 20 cycles: `stall_count` stops at 15.
  - Pulse `stat_clear` in a stall cycle: `stall_count`=0 on the next edge.
- Assert `rst_n` low mid-cycle with `occupancy`=2.
  - Expect an immediate asynchronous `out_valid`=0 and `in_ready`=1.
  - After release, a fresh beat 0x55 appears alone and the old beats never appear.
